// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared types and default parameters for the unified memory arbiter.
package unified_mem_arbiter_pkg;
   localparam int DEF_XLEN           = 32;
   localparam int DEF_STARVE_LIMIT   = 4;
   localparam int DEF_TIMEOUT_CYCLES = 64;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} e_mem_owner;
   typedef enum logic {ARB_IDLE, ARB_WAIT} e_arb_state;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, load-store and memory buses; slave is the arbiter view, master the environment view.
interface unified_mem_arbiter_if #(parameter int XLEN = 32);
   logic            if_req, if_gnt, if_rvalid, if_err;
   logic [XLEN-1:0] if_addr, if_rdata;
   logic            ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
   logic [XLEN/8-1:0] ls_be;
   logic [XLEN-1:0] ls_addr, ls_wdata, ls_rdata;
   logic            mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
   logic [XLEN/8-1:0] mem_be;
   logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata,
             mem_gnt, mem_rvalid, mem_rdata, mem_err,
      output if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata,
             mem_gnt, mem_rvalid, mem_rdata, mem_err,
      input  if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/unified_mem_arbiter_timer.sv
// mem_arb_timer: counts WAIT cycles from a grant and flags when the response deadline is reached.
module mem_arb_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rstn,
   input  logic start,
   input  logic stop,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   logic          running;
   logic [CW-1:0] wait_cnt;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         running  <= 1'b0;
         wait_cnt <= '0;
      end else begin
         running  <= start ? 1'b1 : stop ? 1'b0 : running;
         wait_cnt <= (start || stop) ? '0 : running ? wait_cnt + CW'(1) : wait_cnt;
      end
   end
   assign expired = running && wait_cnt == LAST;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between fetch and load-store,
// LS-priority with a starvation guard, one outstanding transaction, response timeout.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int XLEN           = DEF_XLEN,
   parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input logic clk,
   input logic rstn,
   unified_mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
   e_arb_state    state, state_nx;
   e_mem_owner    owner, owner_nx;
   logic [SW-1:0] streak, streak_nx;
   logic          idle, sel_ls, sel_if, grant, resp, expired, if_resp, ls_resp;
   assign idle   = state == ARB_IDLE;
   assign sel_ls = bus.ls_req && (streak < S_MAX || !bus.if_req);
   assign sel_if = bus.if_req && !sel_ls;
   assign grant  = idle && bus.mem_gnt && (sel_ls || sel_if);
   assign resp   = !idle && (bus.mem_rvalid || expired);
   mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .rstn    (rstn),
      .start   (grant),
      .stop    (resp),
      .expired (expired)
   );
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= ARB_IDLE;
         owner  <= OWN_NONE;
         streak <= '0;
      end else begin
         state  <= state_nx;
         owner  <= owner_nx;
         streak <= streak_nx;
      end
   end
   always_comb begin
      state_nx  = grant ? ARB_WAIT : resp ? ARB_IDLE : state;
      owner_nx  = grant ? (sel_ls ? OWN_LS : OWN_IF) : resp ? OWN_NONE : owner;
      streak_nx = !grant ? streak
                : (sel_ls && bus.if_req) ? (streak == S_MAX ? streak : streak + SW'(1))
                : '0;
   end
   // A real mem_rvalid beats the timeout when both land in the same cycle.
   always_comb begin
      if_resp       = resp && owner == OWN_IF;
      ls_resp       = resp && owner == OWN_LS;
      bus.mem_req   = idle && (bus.if_req || bus.ls_req);
      bus.mem_we    = idle && sel_ls && bus.ls_we;
      bus.mem_be    = !idle ? '0 : sel_ls ? bus.ls_be : sel_if ? '1 : '0;
      bus.mem_addr  = !idle ? '0 : sel_ls ? bus.ls_addr : sel_if ? bus.if_addr : '0;
      bus.mem_wdata = (idle && sel_ls) ? bus.ls_wdata : '0;
      bus.if_gnt    = idle && sel_if && bus.mem_gnt;
      bus.ls_gnt    = idle && sel_ls && bus.mem_gnt;
      bus.if_rvalid = if_resp;
      bus.if_rdata  = (if_resp && bus.mem_rvalid) ? bus.mem_rdata : '0;
      bus.if_err    = if_resp && (!bus.mem_rvalid || bus.mem_err);
      bus.ls_rvalid = ls_resp;
      bus.ls_rdata  = (ls_resp && bus.mem_rvalid) ? bus.mem_rdata : '0;
      bus.ls_err    = ls_resp && (!bus.mem_rvalid || bus.mem_err);
   end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed vectors with hand-computed expectations, checked mid-cycle.
module tb_unified_mem_arbiter;
   import unified_mem_arbiter_pkg::*;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   logic [9:0] exp_if_order = 10'b10_0001_0000;
   unified_mem_arbiter_if #(.XLEN(32)) bus ();
   unified_mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic check_quiet(input string tag);
      check({tag, "_ctl"}, 32'({bus.if_gnt, bus.if_rvalid, bus.if_err, bus.ls_gnt, bus.ls_rvalid,
                               bus.ls_err, bus.mem_req, bus.mem_we}), 32'h0);
      check({tag, "_be"}, 32'(bus.mem_be), 32'h0);
      check({tag, "_addr"}, bus.mem_addr, 32'h0);
      check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
      check({tag, "_rdata"}, bus.if_rdata | bus.ls_rdata, 32'h0);
   endtask
   task automatic step();
      @(negedge clk);
   endtask
   initial begin
      {bus.if_req, bus.ls_req, bus.ls_we, bus.mem_gnt, bus.mem_rvalid, bus.mem_err} = '0;
      bus.if_addr = '0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_be = '0; bus.mem_rdata = '0;
      repeat (2) step();
      #1 check_quiet("reset");
      rstn = 1'b1;
      step();
      #1 check_quiet("post_reset");
      // single fetch
      step();
      bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.mem_gnt = 1'b1;
      #1;
      check("fetch_if_gnt", 32'(bus.if_gnt), 32'h1);
      check("fetch_ls_gnt", 32'(bus.ls_gnt), 32'h0);
      check("fetch_mem_addr", bus.mem_addr, 32'h100);
      check("fetch_mem_be", 32'(bus.mem_be), 32'hf);
      check("fetch_mem_we", 32'(bus.mem_we), 32'h0);
      step();
      bus.if_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h13;
      #1;
      check("fetch_if_rvalid", 32'(bus.if_rvalid), 32'h1);
      check("fetch_if_rdata", bus.if_rdata, 32'h13);
      check("fetch_if_err", 32'(bus.if_err), 32'h0);
      check("fetch_ls_quiet", 32'({bus.ls_gnt, bus.ls_rvalid, bus.ls_err}) | bus.ls_rdata, 32'h0);
      check("fetch_wait_mem_req", 32'(bus.mem_req), 32'h0);
      step();
      bus.mem_rvalid = 1'b0;
      #1 check("fetch_pulse_end", 32'(bus.if_rvalid), 32'h0);
      // contention: LS x4, IF, LS x4, IF
      for (int i = 0; i < 10; i++) begin
         step();
         bus.if_req = 1'b1; bus.ls_req = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0;
         bus.if_addr = 32'h400 + 32'(i); bus.ls_addr = 32'h800 + 32'(i);
         #1;
         check($sformatf("cont_gnt_%0d", i), 32'({bus.if_gnt, bus.ls_gnt}),
               exp_if_order[i] ? 32'h2 : 32'h1);
         check($sformatf("cont_addr_%0d", i), bus.mem_addr,
               exp_if_order[i] ? 32'h400 + 32'(i) : 32'h800 + 32'(i));
         step();
         bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA0 + 32'(i);
         #1;
         check($sformatf("cont_rsp_%0d", i), 32'({bus.if_rvalid, bus.ls_rvalid}),
               exp_if_order[i] ? 32'h2 : 32'h1);
      end
      step();
      bus.if_req = 1'b0; bus.ls_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      #1 check_quiet("cont_idle");
      // store
      step();
      bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_be = 4'b0011; bus.ls_wdata = 32'hDEADBEEF;
      bus.ls_addr = 32'h2000; bus.mem_gnt = 1'b1;
      #1;
      check("store_ls_gnt", 32'(bus.ls_gnt), 32'h1);
      check("store_mem_we", 32'(bus.mem_we), 32'h1);
      check("store_mem_be", 32'(bus.mem_be), 32'h3);
      check("store_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
      check("store_mem_addr", bus.mem_addr, 32'h2000);
      step();
      bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 32'h55;
      #1;
      check("store_ls_rvalid", 32'(bus.ls_rvalid), 32'h1);
      check("store_ls_rdata", bus.ls_rdata, 32'h55);
      check("store_if_quiet", 32'({bus.if_gnt, bus.if_rvalid}), 32'h0);
      // timeout after 8 WAIT cycles, then a stray late response
      step();
      bus.mem_rvalid = 1'b0; bus.ls_req = 1'b1; bus.ls_addr = 32'h300; bus.ls_be = 4'hf;
      bus.mem_gnt = 1'b1;
      #1 check("to_ls_gnt", 32'(bus.ls_gnt), 32'h1);
      step();
      bus.ls_req = 1'b0; bus.mem_gnt = 1'b0;
      for (int k = 1; k < 8; k++) begin
         #1 check($sformatf("to_wait_%0d", k), 32'(bus.ls_rvalid), 32'h0);
         step();
      end
      #1;
      check("to_ls_rvalid", 32'(bus.ls_rvalid), 32'h1);
      check("to_ls_err", 32'(bus.ls_err), 32'h1);
      check("to_ls_rdata", bus.ls_rdata, 32'h0);
      step();
      #1 check("to_after", 32'(bus.ls_rvalid), 32'h0);
      step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAB;
      #1 check("stray_rvalid", 32'({bus.if_rvalid, bus.ls_rvalid, bus.ls_err}), 32'h0);
      // real response in the deadline cycle wins over the timeout
      step();
      bus.mem_rvalid = 1'b0; bus.ls_req = 1'b1; bus.mem_gnt = 1'b1;
      #1 check("win_ls_gnt", 32'(bus.ls_gnt), 32'h1);
      step();
      bus.ls_req = 1'b0; bus.mem_gnt = 1'b0;
      repeat (7) step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77;
      #1;
      check("win_ls_rvalid", 32'(bus.ls_rvalid), 32'h1);
      check("win_ls_err", 32'(bus.ls_err), 32'h0);
      check("win_ls_rdata", bus.ls_rdata, 32'h77);
      // memory error on a fetch
      step();
      bus.mem_rvalid = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h104; bus.mem_gnt = 1'b1;
      #1 check("merr_if_gnt", 32'(bus.if_gnt), 32'h1);
      step();
      bus.if_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_err = 1'b1;
      bus.mem_rdata = 32'h0;
      #1 check("merr_if_rsp", 32'({bus.if_rvalid, bus.if_err}), 32'h3);
      // reset while waiting drops the in-flight response
      step();
      bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
      bus.if_req = 1'b1; bus.ls_req = 1'b1; bus.mem_gnt = 1'b1;
      #1 check("rst_ls_gnt", 32'({bus.if_gnt, bus.ls_gnt}), 32'h1);
      step();
      bus.if_req = 1'b0; bus.ls_req = 1'b0; bus.mem_gnt = 1'b0;
      #1 check("rst_streak_pre", 32'(dut.streak), 32'h1);
      rstn = 1'b0;
      #1;
      check_quiet("rst_mid");
      check("rst_streak", 32'(dut.streak), 32'h0);
      step();
      rstn = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h99;
      #1;
      check("rst_no_rvalid", 32'({bus.if_rvalid, bus.ls_rvalid}), 32'h0);
      check("rst_state", 32'(dut.state), 32'(ARB_IDLE));
      check_quiet("rst_after");
      step();
      bus.mem_rvalid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
